// File: rtl/cpu_clock_skeleton_pkg.sv
// Shared constants and helpers for the processor clock-phase generator.
// DIV is the number of master cycles per processor step; WARMUP is the post-reset hold-off.
package cpu_clock_skeleton_pkg;

  localparam int DIV_DEFAULT    = 4;
  localparam int WARMUP_DEFAULT = 2;

  // Width of a counter that spans 0..n-1 (never narrower than one bit).
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  localparam int PH_W = cnt_width(DIV_DEFAULT);

  // Bit positions of the four sub-clocks inside the decode vector.
  typedef enum logic [1:0] {
    CLK_IMEM = 2'd0,
    CLK_DMEM = 2'd1,
    CLK_PROC = 2'd2,
    CLK_REGF = 2'd3
  } sub_clock_e;

  localparam int N_SUB = 4;

endpackage

// File: rtl/cpu_clock_skeleton_phase_counter.sv
// Warm-up and step-phase counters. Exposes both the registered state and the
// value it takes on the coming edge, so the output flops can decode the new phase.
module phase_counter
  import cpu_clock_skeleton_pkg::*;
#(
  parameter int DIV    = DIV_DEFAULT,
  parameter int WARMUP = WARMUP_DEFAULT,
  parameter int PW     = cnt_width(DIV)
) (
  input  logic          clock,
  input  logic          reset,
  output logic [PW-1:0] ph,
  output logic [PW-1:0] ph_next,
  output logic          run,
  output logic          run_next
);

  localparam int WU_W = cnt_width(WARMUP + 1);

  logic [PW-1:0]   ph_reg;
  logic [WU_W-1:0] wu_reg;
  logic [WU_W-1:0] wu_next;
  logic            run_reg;

  always_comb begin
    ph_next  = ph_reg;
    wu_next  = wu_reg;
    run_next = run_reg;
    if (run_reg) begin
      ph_next = (ph_reg == PW'(DIV - 1)) ? '0 : ph_reg + 1'b1;
    end else begin
      wu_next = wu_reg + 1'b1;
      // The edge that sees the last warm-up count starts the first step at phase 0.
      if (wu_reg == WU_W'(WARMUP - 1)) begin
        run_next = 1'b1;
        ph_next  = '0;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ph_reg  <= '0;
      wu_reg  <= '0;
      run_reg <= 1'b0;
    end else begin
      ph_reg  <= ph_next;
      wu_reg  <= wu_next;
      run_reg <= run_next;
    end
  end

  assign ph  = ph_reg;
  assign run = run_reg;

endmodule

// File: rtl/cpu_clock_skeleton.sv
// Four registered, glitch-free sub-clocks for the single-cycle processor skeleton,
// each with a period of DIV master cycles and a fixed phase order within a step.
module cpu_clock_skeleton
  import cpu_clock_skeleton_pkg::*;
#(
  parameter int DIV    = DIV_DEFAULT,
  parameter int WARMUP = WARMUP_DEFAULT
) (
  input  logic clock,
  input  logic reset,
  output logic imem_clock,
  output logic dmem_clock,
  output logic processor_clock,
  output logic regfile_clock
);

  localparam int PW = cnt_width(DIV);
  localparam logic [PW-1:0] HALF = PW'(DIV / 2);

  logic [PW-1:0]    ph;
  logic [PW-1:0]    ph_next;
  logic             run;
  logic             run_next;
  logic [N_SUB-1:0] sub_next;
  logic [N_SUB-1:0] sub_reg;

  phase_counter #(
    .DIV    (DIV),
    .WARMUP (WARMUP),
    .PW     (PW)
  ) u_phase (
    .clock    (clock),
    .reset    (reset),
    .ph       (ph),
    .ph_next  (ph_next),
    .run      (run),
    .run_next (run_next)
  );

  // Decode the phase the counter is about to enter so each output is a plain flop.
  always_comb begin
    sub_next = '0;
    if (run_next) begin
      sub_next[CLK_PROC] = (ph_next < HALF);
      sub_next[CLK_REGF] = (ph_next < HALF);
      sub_next[CLK_IMEM] = (ph_next != '0) && (ph_next <= HALF);
      sub_next[CLK_DMEM] = (ph_next >= HALF);
    end
  end

  for (genvar gi = 0; gi < N_SUB; gi++) begin : g_sub_flop
    always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
        sub_reg[gi] <= 1'b0;
      end else begin
        sub_reg[gi] <= sub_next[gi];
      end
    end
  end

  assign imem_clock      = sub_reg[CLK_IMEM];
  assign dmem_clock      = sub_reg[CLK_DMEM];
  assign processor_clock = sub_reg[CLK_PROC];
  assign regfile_clock   = sub_reg[CLK_REGF];

endmodule

// File: tb/tb_cpu_clock_skeleton.sv
// Randomised reset-pulse bench for cpu_clock_skeleton (DIV=4/WARMUP=2 and DIV=8/WARMUP=3).
// Expected outputs come from counting edges since reset release.
`timescale 1ns/1ps
module tb_cpu_clock_skeleton;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  logic p4, r4, i4, d4;
  logic p8, r8, i8, d8;

  cpu_clock_skeleton #(.DIV(4), .WARMUP(2)) u_dut4 (
    .clock           (clock),
    .reset           (reset),
    .imem_clock      (i4),
    .dmem_clock      (d4),
    .processor_clock (p4),
    .regfile_clock   (r4)
  );

  cpu_clock_skeleton #(.DIV(8), .WARMUP(3)) u_dut8 (
    .clock           (clock),
    .reset           (reset),
    .imem_clock      (i8),
    .dmem_clock      (d8),
    .processor_clock (p8),
    .regfile_clock   (r8)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int edges = 0;
  bit armed = 1'b0;
  bit first_run = 1'b0;

  // Hand-derived first-run waveforms for DIV=4/WARMUP=2, indexed by edges since release.
  logic [1:9] proc_lit = 9'b0_1100_1100;
  logic [1:9] imem_lit = 9'b0_0110_0110;
  logic [1:9] dmem_lit = 9'b0_0011_0011;

  // Edges seen with reset released; reset only moves between edges.
  always @(posedge clock) edges <= reset ? edges + 1 : 0;

  // Expected {processor, regfile, imem, dmem}.
  function automatic logic [3:0] model(input int div, input int warm, input int e, input logic r);
    int ph;
    if (!r || e < warm) return 4'b0000;
    ph = (e - warm) % div;
    return {ph < div / 2, ph < div / 2, (ph >= 1) && (ph <= div / 2), ph >= div / 2};
  endfunction

  task automatic check(input string name, input logic [3:0] got, input logic [3:0] req);
    n_cmp++;
    if (got !== req) begin
      n_bad++;
      $display("FAIL %s t=%0t edges=%0d reset=%b got=%b required=%b",
               name, $time, edges, reset, got, req);
    end
  endtask

  always @(negedge clock) begin
    if (armed) begin
      check("div4", {p4, r4, i4, d4}, model(4, 2, edges, reset));
      check("div8", {p8, r8, i8, d8}, model(8, 3, edges, reset));
      if (first_run && reset && edges >= 1 && edges <= 9) begin
        check("pin_proc", {3'b000, p4}, {3'b000, proc_lit[edges]});
        check("pin_imem", {3'b000, i4}, {3'b000, imem_lit[edges]});
        check("pin_dmem", {3'b000, d4}, {3'b000, dmem_lit[edges]});
      end
    end
  end

  // Step to n posedges later, then a little past the edge so inputs move away from it.
  task automatic adv(input int n);
    repeat (n) @(posedge clock);
    #2;
  endtask

  initial begin
    int guard;
    adv(2);
    armed = 1'b1;
    adv(2);
    first_run = 1'b1;
    reset = 1'b1;
    adv(20);

    // Pull reset while processor_clock is high; outputs must clear before the next edge.
    guard = 0;
    while (p4 !== 1'b1 && guard < 16) begin
      adv(1);
      guard++;
    end
    if (p4 !== 1'b1) begin
      $display("FAIL wait_proc_high got=%b required=1 after %0d edges", p4, guard);
      $fatal(1);
    end
    first_run = 1'b0;
    reset = 1'b0;
    adv(2);
    reset = 1'b1;
    adv(12);

    for (int k = 0; k < 40; k++) begin
      adv($urandom_range(1, 30));
      reset = 1'b0;
      adv($urandom_range(1, 3));
      reset = 1'b1;
    end

    adv(10);
    reset = 1'b0;
    adv(100);
    @(negedge clock);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
